reg_bank_16xn: RTL and testbench

- 16-entry x N-bit register bank: one synchronous write port, two registered read ports.
- Sits directly upstream of the 16:1 N-bit read multiplexers and supplies their 16 data inputs; the read-port selection is done by those muxes.
- Adds write-through bypass, an optional hardwired-zero R0, and a sequenced clear-all engine, which zeroes one register per cycle under a busy flag.

---
 rtl/reg_bank_16xn_pkg.sv | 19 +
 rtl/mux16x1N.sv | 25 ++
 rtl/reg_bank_clr_fsm.sv | 69 ++++++
 rtl/reg_bank_16xn.sv | 120 ++++++++++++
 tb/tb_reg_bank_16xn.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/reg_bank_16xn_pkg.sv
// -----------------------------------------------------------------------------
// reg_bank_16xn_pkg
// Shared definitions for the 16-entry register bank: bank geometry, the
// clear-sequencer state encoding and the register reset value.
// -----------------------------------------------------------------------------
package reg_bank_16xn_pkg;

   localparam int unsigned NREGS = 16;
   localparam int unsigned AW    = 4;

   typedef enum logic [0:0] {
      StIdle,
      StClear
   } clr_state_e;

   // Every register bit resets (and clears) to this value; replicate to width.
   localparam logic RegRstBit = 1'b0;

endpackage

// File: rtl/mux16x1N.sv
// -----------------------------------------------------------------------------
// mux16x1N
// 16:1 multiplexer, N bits wide, purely combinational.
// Ports:
//   i_d   - 16 packed N-bit inputs, input k at bits [k*N +: N]
//   i_sel - 4-bit input select
//   o_y   - selected N-bit input
// -----------------------------------------------------------------------------
module mux16x1N #(
   parameter int unsigned N = 8
) (
   input  logic [16*N-1:0] i_d,
   input  logic [3:0]      i_sel,
   output logic [N-1:0]    o_y
);

   logic [N-1:0] w_in [16];

   for (genvar g = 0; g < 16; g++) begin : g_unpack
      assign w_in[g] = i_d[g*N +: N];
   end

   assign o_y = w_in[i_sel];

endmodule

// File: rtl/reg_bank_clr_fsm.sv
// -----------------------------------------------------------------------------
// reg_bank_clr_fsm
// Clear-all sequencer: on a start pulse in idle, walks a 4-bit index from 0
// to 15, one register per cycle, then returns to idle.
// Ports:
//   i_clk, i_rst - clock and asynchronous active-high reset
//   i_clr_req    - start pulse, ignored while a sequence is running
//   o_busy       - high while the sequence runs (exactly 16 cycles)
//   o_clr_en     - zero register o_clr_idx at the next rising edge
//   o_clr_idx    - index of the register being cleared this cycle
// -----------------------------------------------------------------------------
module reg_bank_clr_fsm
   import reg_bank_16xn_pkg::*;
(
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_clr_req,
   output logic          o_busy,
   output logic          o_clr_en,
   output logic [AW-1:0] o_clr_idx
);

   clr_state_e    r_state;
   clr_state_e    w_state_next;
   logic [AW-1:0] r_cnt;
   logic [AW-1:0] w_cnt_next;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= StIdle;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      unique case (r_state)
         StIdle: begin
            if (i_clr_req) begin
               w_state_next = StClear;
               w_cnt_next   = '0;
            end
         end
         StClear: begin
            // Leaving on the last index keeps the counter from ever wrapping
            // inside the sequence.
            if (r_cnt == AW'(NREGS - 1)) begin
               w_state_next = StIdle;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next = r_cnt + 4'd1;
            end
         end
         default: begin
            w_state_next = StIdle;
            w_cnt_next   = '0;
         end
      endcase
   end

   assign o_busy    = (r_state == StClear);
   assign o_clr_en  = o_busy;
   assign o_clr_idx = r_cnt;

endmodule

// File: rtl/reg_bank_16xn.sv
// -----------------------------------------------------------------------------
// reg_bank_16xn
// 16 x N register bank with one synchronous write port and two registered
// read ports, write-first bypass, optional hardwired-zero R0 and a sequenced
// clear-all engine.
// Ports:
//   i_clk, i_rst         - clock and asynchronous active-high reset
//   i_we, i_waddr,
//   i_wdata              - write port; dropped while busy, on a clear start,
//                          or to R0 when ZERO_R0 is set
//   i_raddr_a, i_raddr_b - read indices, sampled at the rising edge
//   o_rdata_a, o_rdata_b - registered read data (1-cycle latency)
//   i_clr_req            - pulse to start clearing all registers
//   o_busy               - high while the clear sequence runs
// -----------------------------------------------------------------------------
module reg_bank_16xn
   import reg_bank_16xn_pkg::*;
#(
   parameter int unsigned N       = 8,
   parameter bit          ZERO_R0 = 1'b1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [N-1:0]  i_wdata,
   input  logic [AW-1:0] i_raddr_a,
   input  logic [AW-1:0] i_raddr_b,
   output logic [N-1:0]  o_rdata_a,
   output logic [N-1:0]  o_rdata_b,
   input  logic          i_clr_req,
   output logic          o_busy
);

   logic [N-1:0]       r_regs [NREGS];
   logic [N-1:0]       r_rdata_a;
   logic [N-1:0]       r_rdata_b;
   logic [NREGS*N-1:0] w_regs_flat;
   logic [N-1:0]       w_mux_a;
   logic [N-1:0]       w_mux_b;
   logic [N-1:0]       w_sel_a;
   logic [N-1:0]       w_sel_b;
   logic               w_busy;
   logic               w_clr_en;
   logic [AW-1:0]      w_clr_idx;
   logic               w_wr_acc;

   reg_bank_clr_fsm u_clr_fsm (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_clr_req (i_clr_req),
      .o_busy    (w_busy),
      .o_clr_en  (w_clr_en),
      .o_clr_idx (w_clr_idx)
   );

   // A clear request in idle takes priority over a simultaneous write.
   assign w_wr_acc = i_we && !w_busy && !i_clr_req && !(ZERO_R0 && (i_waddr == '0));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= {N{RegRstBit}};
         end
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (w_clr_en && (w_clr_idx == AW'(i))) begin
               r_regs[i] <= {N{RegRstBit}};
            end else if (w_wr_acc && (i_waddr == AW'(i))) begin
               r_regs[i] <= i_wdata;
            end
         end
      end
   end

   for (genvar g = 0; g < NREGS; g++) begin : g_flat
      assign w_regs_flat[g*N +: N] = r_regs[g];
   end

   mux16x1N #(
      .N (N)
   ) u_mux_a (
      .i_d   (w_regs_flat),
      .i_sel (i_raddr_a),
      .o_y   (w_mux_a)
   );

   mux16x1N #(
      .N (N)
   ) u_mux_b (
      .i_d   (w_regs_flat),
      .i_sel (i_raddr_b),
      .o_y   (w_mux_b)
   );

   // Zero-R0 override sits after bypass so it always wins.
   always_comb begin
      w_sel_a = w_mux_a;
      if (w_wr_acc && (i_waddr == i_raddr_a)) w_sel_a = i_wdata;
      if (ZERO_R0 && (i_raddr_a == '0))       w_sel_a = '0;
      w_sel_b = w_mux_b;
      if (w_wr_acc && (i_waddr == i_raddr_b)) w_sel_b = i_wdata;
      if (ZERO_R0 && (i_raddr_b == '0))       w_sel_b = '0;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rdata_a <= '0;
         r_rdata_b <= '0;
      end else begin
         r_rdata_a <= w_sel_a;
         r_rdata_b <= w_sel_b;
      end
   end

   assign o_rdata_a = r_rdata_a;
   assign o_rdata_b = r_rdata_b;
   assign o_busy    = w_busy;

endmodule

// File: tb/tb_reg_bank_16xn.sv
module tb_reg_bank_16xn;

   logic       clk;
   logic       rst;
   logic       we;
   logic [3:0] waddr;
   logic [7:0] wdata;
   logic [3:0] raddr_a;
   logic [3:0] raddr_b;
   logic       clr_req;
   logic [7:0] rdata_a;
   logic [7:0] rdata_b;
   logic       busy;
   logic [7:0] rdata_a_nz;
   logic [7:0] rdata_b_nz;
   logic       busy_nz;

   int n_tests = 0;
   int n_fail  = 0;

   // R0 hardwired to zero
   reg_bank_16xn #(.N(8), .ZERO_R0(1'b1)) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_we      (we),
      .i_waddr   (waddr),
      .i_wdata   (wdata),
      .i_raddr_a (raddr_a),
      .i_raddr_b (raddr_b),
      .o_rdata_a (rdata_a),
      .o_rdata_b (rdata_b),
      .i_clr_req (clr_req),
      .o_busy    (busy)
   );

   // R0 ordinary register, same stimulus
   reg_bank_16xn #(.N(8), .ZERO_R0(1'b0)) dut_nz (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_we      (we),
      .i_waddr   (waddr),
      .i_wdata   (wdata),
      .i_raddr_a (raddr_a),
      .i_raddr_b (raddr_b),
      .o_rdata_a (rdata_a_nz),
      .o_rdata_b (rdata_b_nz),
      .i_clr_req (clr_req),
      .o_busy    (busy_nz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      we    = 1'b1;
      waddr = a;
      wdata = d;
      tick();
      we    = 1'b0;
   endtask

   // Read all 16 entries on both ports of both banks and expect zero.
   task automatic check_all_zero(input string tag);
      for (int i = 0; i < 16; i++) begin
         raddr_a = 4'(i);
         raddr_b = 4'(15 - i);
         tick();
         chk({tag, "_a"}, rdata_a, 8'h00);
         chk({tag, "_b"}, rdata_b, 8'h00);
         chk({tag, "_a_nz"}, rdata_a_nz, 8'h00);
         chk({tag, "_b_nz"}, rdata_b_nz, 8'h00);
      end
   endtask

   int busy_cnt;

   initial begin
      rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
      raddr_a = '0; raddr_b = '0; clr_req = 1'b0;
      tick();
      tick();
      chk("rst_busy", busy, 1'b0);
      chk("rst_rdata_a", rdata_a, 8'h00);
      chk("rst_rdata_b", rdata_b, 8'h00);
      rst = 1'b0;

      check_all_zero("reset_read");
      chk("idle_busy", busy, 1'b0);

      // Plain write then read on both ports
      wr(4'd3, 8'hA5);
      raddr_a = 4'd3; raddr_b = 4'd3;
      tick();
      chk("r3_a", rdata_a, 8'hA5);
      chk("r3_b", rdata_b, 8'hA5);

      // Write-first bypass
      raddr_a = 4'd7;
      raddr_b = 4'd3;
      wr(4'd7, 8'h3C);
      chk("bypass_r7", rdata_a, 8'h3C);
      chk("r3_held", rdata_b, 8'hA5);

      // R0: same-cycle write/read, then a later read
      raddr_a = 4'd0;
      wr(4'd0, 8'hFF);
      chk("r0_bypass_zero", rdata_a, 8'h00);
      chk("r0_bypass_nz", rdata_a_nz, 8'hFF);
      tick();
      chk("r0_zero", rdata_a, 8'h00);
      chk("r0_nz", rdata_a_nz, 8'hFF);

      // Load R0..R15 with 0x10+i
      for (int i = 0; i < 16; i++) wr(4'(i), 8'(8'h10 + i));

      // Clear start with a competing write to R5; clear must win
      raddr_a = 4'd9;
      raddr_b = 4'd5;
      we = 1'b1; waddr = 4'd5; wdata = 8'h77; clr_req = 1'b1;
      tick();
      we = 1'b0; clr_req = 1'b0;
      chk("clr_start_r5", rdata_b, 8'h15);
      busy_cnt = 0;
      for (int k = 0; k < 40; k++) begin
         if (!busy) break;
         busy_cnt++;
         if (k == 4) begin
            chk("clr_r9_cyc4", rdata_a, 8'h19);
            chk("clr_r9_cyc4_nz", rdata_a_nz, 8'h19);
         end
         if (k == 11) chk("clr_r9_cleared", rdata_a, 8'h00);
         chk("clr_r5_not77", 32'(rdata_b == 8'h77), 32'd0);
         // A second request mid-sequence must not restart it
         clr_req = (k == 8);
         tick();
      end
      clr_req = 1'b0;
      chk("busy_cycles", busy_cnt, 16);
      chk("busy_cycles_nz", busy_nz ? 0 : 1, 1);
      check_all_zero("after_clear");

      // Reset in the middle of a clear
      wr(4'd10, 8'h99);
      wr(4'd12, 8'h55);
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      chk("pre_rst_busy", busy, 1'b1);
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_rdata_a", rdata_a, 8'h00);
      tick();
      rst = 1'b0;
      raddr_a = 4'd10;
      raddr_b = 4'd12;
      tick();
      chk("post_rst_r10", rdata_a, 8'h00);
      chk("post_rst_r12", rdata_b, 8'h00);
      chk("post_rst_busy", busy, 1'b0);
      raddr_a = 4'd2;
      wr(4'd2, 8'h42);
      tick();
      chk("post_rst_r2", rdata_a, 8'h42);
      chk("post_rst_r2_nz", rdata_a_nz, 8'h42);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
